// File: rtl/uart_keyword_ctrl.sv
// Watches the UART RX byte stream for a keyword and, on a full match, issues a
// fixed-width reset request followed by a hold-off window that discards bytes.
module uart_keyword_ctrl #(
  parameter int                   KEY_LEN     = 6,
  parameter logic [8*KEY_LEN-1:0] KEYWORD     = 48'h496E636F7272,
  parameter int                   TIMEOUT_CYC = 1000000,
  parameter int                   PULSE_LEN   = 4,
  parameter int                   HOLDOFF_CYC = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       arm,
  output logic       reset_req,
  output logic [2:0] match_cnt,
  output logic       busy,
  output logic [7:0] hits
);

  localparam int TW        = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int PHASE_MAX = (PULSE_LEN > HOLDOFF_CYC) ? PULSE_LEN : HOLDOFF_CYC;
  localparam int PW        = $clog2(PHASE_MAX + 1);

  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYC);
  localparam logic [PW-1:0] PULSE_LAST  = PW'(PULSE_LEN - 1);
  localparam logic [PW-1:0] HOLD_LAST   = PW'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);
  localparam logic [3:0]    KEY_LEN_V   = 4'(KEY_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MATCH,
    S_FIRE,
    S_HOLDOFF
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    match_cnt_q, match_cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          reset_req_q, reset_req_d;
  logic          busy_q, busy_d;
  logic [7:0]    hits_q, hits_d;

  logic          timeout_hit;
  logic [2:0]    base_cnt;
  logic [3:0]    next_cnt;

  // Keyword bytes in stream order; unused slots are never indexed.
  logic [7:0] kw_byte [8];
  for (genvar gi = 0; gi < 8; gi++) begin : g_kw
    if (gi < KEY_LEN) begin : g_used
      assign kw_byte[gi] = KEYWORD[8*(KEY_LEN-1-gi) +: 8];
    end else begin : g_unused
      assign kw_byte[gi] = 8'h00;
    end
  end

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    idle_d      = idle_q;
    phase_d     = phase_q;
    reset_req_d = reset_req_q;
    busy_d      = busy_q;
    hits_d      = hits_q;

    // A byte landing on the timeout cycle is judged as the start of a new attempt.
    timeout_hit = (TIMEOUT_CYC != 0) && (state_q == S_MATCH) && (idle_q == TIMEOUT_VAL);
    base_cnt    = timeout_hit ? 3'd0 : match_cnt_q;
    next_cnt    = {1'b0, base_cnt} + 4'd1;

    case (state_q)
      S_IDLE, S_MATCH: begin
        if (!arm) begin
          state_d     = S_IDLE;
          match_cnt_d = '0;
          idle_d      = '0;
        end else begin
          if (timeout_hit) begin
            state_d     = S_IDLE;
            match_cnt_d = '0;
            idle_d      = '0;
          end else if (state_q == S_MATCH && TIMEOUT_CYC != 0) begin
            idle_d = idle_q + TW'(1);
          end

          if (rx_valid) begin
            idle_d = '0;
            if (rx_data == kw_byte[base_cnt]) begin
              if (next_cnt == KEY_LEN_V) begin
                state_d     = S_FIRE;
                match_cnt_d = '0;
                phase_d     = '0;
                reset_req_d = 1'b1;
                busy_d      = 1'b1;
                if (hits_q != 8'hFF) begin
                  hits_d = hits_q + 8'd1;
                end
              end else begin
                state_d     = S_MATCH;
                match_cnt_d = next_cnt[2:0];
              end
            end else if (rx_data == kw_byte[0]) begin
              state_d     = S_MATCH;
              match_cnt_d = 3'd1;
            end else begin
              state_d     = S_IDLE;
              match_cnt_d = '0;
            end
          end
        end
      end

      S_FIRE: begin
        if (phase_q == PULSE_LAST) begin
          reset_req_d = 1'b0;
          phase_d     = '0;
          if (HOLDOFF_CYC == 0) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = S_HOLDOFF;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      S_HOLDOFF: begin
        if (phase_q == HOLD_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      default: begin
        state_d     = S_IDLE;
        match_cnt_d = '0;
        idle_d      = '0;
        phase_d     = '0;
        reset_req_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      match_cnt_q <= '0;
      idle_q      <= '0;
      phase_q     <= '0;
      reset_req_q <= 1'b0;
      busy_q      <= 1'b0;
      hits_q      <= '0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      idle_q      <= idle_d;
      phase_q     <= phase_d;
      reset_req_q <= reset_req_d;
      busy_q      <= busy_d;
      hits_q      <= hits_d;
    end
  end

  assign reset_req = reset_req_q;
  assign match_cnt = match_cnt_q;
  assign busy      = busy_q;
  assign hits      = hits_q;

endmodule

// File: tb/tb_uart_keyword_ctrl.sv
// Directed and randomized checks of uart_keyword_ctrl against a timestamp-based
// model: each completed keyword opens a pulse window and a byte-discard window.
module tb_uart_keyword_ctrl;

  localparam int TMO   = 16;
  localparam int PULSE = 4;
  localparam int HOLD  = 100;
  localparam int KLEN  = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       arm = 1'b0;
  logic       reset_req;
  logic [2:0] match_cnt;
  logic       busy;
  logic [7:0] hits;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  string kw    = "Incorr";

  // model: progress, time of last evaluated byte, hit count, fire edge, end of discard window
  int m_cnt, m_last, m_hits, m_fire, m_block;
  int rr_cnt, busy_cnt, first_rr, last_byte_cyc;

  uart_keyword_ctrl #(
    .KEY_LEN    (KLEN),
    .KEYWORD    (48'h496E636F7272),
    .TIMEOUT_CYC(TMO),
    .PULSE_LEN  (PULSE),
    .HOLDOFF_CYC(HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .arm      (arm),
    .reset_req(reset_req),
    .match_cnt(match_cnt),
    .busy     (busy),
    .hits     (hits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_last   = 0;
    m_hits   = 0;
    m_fire   = -1000000;
    m_block  = -1000000;
    rr_cnt   = 0;
    busy_cnt = 0;
    first_rr = -1;
  endtask

  task automatic model_edge(input int e, input logic a, input logic v, input logic [7:0] d);
    if (e <= m_block) return;
    if (!a) begin
      m_cnt = 0;
      return;
    end
    if (m_cnt > 0 && e - m_last > TMO) m_cnt = 0;
    if (v) begin
      m_last = e;
      if (d == kw[m_cnt]) m_cnt++;
      else if (d == kw[0]) m_cnt = 1;
      else m_cnt = 0;
      if (m_cnt == KLEN) begin
        m_cnt = 0;
        if (m_hits < 255) m_hits++;
        m_fire  = e;
        m_block = e + PULSE + HOLD;
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic a);
    rx_valid = v;
    rx_data  = d;
    arm      = a;
    @(posedge clk);
    cyc++;
    model_edge(cyc, a, v, d);
    if (v) last_byte_cyc = cyc;
    #1;
    chk("reset_req", {31'd0, reset_req}, {31'd0, (cyc >= m_fire && cyc < m_fire + PULSE)});
    chk("busy", {31'd0, busy}, {31'd0, (cyc >= m_fire && cyc < m_fire + PULSE + HOLD)});
    chk("match_cnt", {29'd0, match_cnt}, m_cnt);
    chk("hits", {24'd0, hits}, m_hits);
    if (reset_req === 1'b1) begin
      rr_cnt++;
      if (first_rr < 0) first_rr = cyc;
    end
    if (busy === 1'b1) busy_cnt++;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic a);
    repeat (n) step(1'b0, 8'h00, a);
  endtask

  task automatic send_str(input string s, input int gap, input logic a);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i], a);
      idle(gap, a);
    end
  endtask

  // Asserts rst_n between clock edges and checks the outputs clear without a clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_reset_req", {31'd0, reset_req}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_hits", {24'd0, hits}, 0);
    chk("rst_match_cnt", {29'd0, match_cnt}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int r_cyc;
    logic [7:0] d;
    logic a;
    string noise;

    noise = "Ixyo";
    model_reset();
    last_byte_cyc = 0;

    // 1: basic match with one idle clock between bytes
    do_reset();
    send_str("xIncorr", 1, 1'b1);
    r_cyc = last_byte_cyc;
    step(1'b1, 8'h79, 1'b1);
    idle(115, 1'b1);
    chk("t1_latency", first_rr, r_cyc);
    chk("t1_pulse_len", rr_cnt, PULSE);
    chk("t1_busy_len", busy_cnt, PULSE + HOLD);
    chk("t1_hits", {24'd0, hits}, 1);

    // 2: repeated first byte restarts at 1
    do_reset();
    send_str("II", 0, 1'b1);
    chk("t2_restart_cnt", {29'd0, match_cnt}, 1);
    send_str("ncorr", 0, 1'b1);
    idle(110, 1'b1);
    chk("t2_pulse_len", rr_cnt, PULSE);
    chk("t2_hits", {24'd0, hits}, 1);

    // 3: inter-byte timeout
    do_reset();
    send_str("Inc", 0, 1'b1);
    idle(TMO, 1'b1);
    chk("t3_before_timeout", {29'd0, match_cnt}, 3);
    idle(1, 1'b1);
    chk("t3_after_timeout", {29'd0, match_cnt}, 0);
    send_str("Inc", 0, 1'b1);
    idle(TMO, 1'b1);
    send_str("orr", 0, 1'b1);
    idle(10, 1'b1);
    chk("t3_no_fire", rr_cnt, 0);
    chk("t3_no_hits", {24'd0, hits}, 0);
    send_str("Inc", 0, 1'b1);
    idle(TMO - 1, 1'b1);
    send_str("orr", 0, 1'b1);
    idle(110, 1'b1);
    chk("t3_gap15_fires", rr_cnt, PULSE);
    chk("t3_gap15_hits", {24'd0, hits}, 1);

    // 4: keyword during hold-off is discarded
    do_reset();
    send_str("IncorrIncorr", 0, 1'b1);
    idle(110, 1'b1);
    chk("t4_holdoff_hits", {24'd0, hits}, 1);
    send_str("Incorr", 0, 1'b1);
    idle(110, 1'b1);
    chk("t4_after_hits", {24'd0, hits}, 2);

    // 5: disarm mid-match and during the pulse
    do_reset();
    send_str("Inco", 0, 1'b1);
    chk("t5_partial", {29'd0, match_cnt}, 4);
    step(1'b0, 8'h00, 1'b0);
    chk("t5_disarm_cnt", {29'd0, match_cnt}, 0);
    send_str("Incorr", 0, 1'b1);
    idle(110, 1'b0);
    chk("t5_pulse_len", rr_cnt, PULSE);
    chk("t5_hits", {24'd0, hits}, 1);

    // 6: async reset mid-pulse, then saturation of hits
    do_reset();
    send_str("Incorr", 0, 1'b1);
    idle(2, 1'b1);
    chk("t6_in_fire", {31'd0, reset_req}, 1);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send_str("Incorr", 0, 1'b1);
      idle(PULSE + HOLD + 1, 1'b1);
    end
    chk("t6_hits_sat", {24'd0, hits}, 255);

    // randomized: bytes biased toward the next expected keyword byte
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      a = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 9) < 7) d = kw[m_cnt];
        else d = noise[$urandom_range(0, 3)];
        step(1'b1, d, a);
      end else if ($urandom_range(0, 30) == 0) begin
        idle($urandom_range(10, 20), a);
      end else begin
        step(1'b0, 8'h00, a);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
